// File: rtl/sba_slave_pkg.sv
// Shared types and default parameters for the SBA slave memory.
package sba_slave_pkg;

   localparam logic [31:0] DefBaseAddr       = 32'h0000_0000;
   localparam int          DefMemWords       = 256;
   localparam int          DefLatency        = 1;
   localparam int          DefMaxOutstanding = 2;

   // One in-flight response travelling down the delay line.
   typedef struct packed {
      logic        valid;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

endpackage

// File: rtl/sba_slave_pipe.sv
// Fixed-latency response delay line; an entry entering at a grant edge
// appears at out_o exactly Latency cycles later.
module sba_slave_pipe
   import sba_slave_pkg::*;
#(
   parameter int Latency = DefLatency
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  resp_t in_i,
   output resp_t out_o
);

   resp_t [Latency-1:0] stage_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_q <= '0;
      end else begin
         stage_q[0] <= in_i;
         for (int i = 1; i < Latency; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_o = stage_q[Latency-1];

endmodule

// File: rtl/sba_slave_mem.sv
// Word-addressed SBA slave memory with byte enables, fixed response latency
// and a bounded number of outstanding requests.
module sba_slave_mem
   import sba_slave_pkg::*;
#(
   parameter logic [31:0] BaseAddr       = DefBaseAddr,
   parameter int          MemWords       = DefMemWords,
   parameter int          Latency        = DefLatency,
   parameter int          MaxOutstanding = DefMaxOutstanding
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int              IdxW   = $clog2(MemWords);
   localparam int              CntW   = 3;
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   logic [31:0]     mem_q [MemWords];
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     off;
   logic [IdxW-1:0] idx;
   logic            in_range;
   logic            retire;
   resp_t           ent_in, ent_out;

   // Unsigned wrap makes addresses below BaseAddr land far out of range.
   assign off      = addr_i - BaseAddr;
   assign in_range = (off >> 2) < 32'(MemWords);
   assign idx      = off[IdxW+1:2];
   assign retire   = ent_out.valid;
   assign gnt_o    = req_i && ((cnt_q < MaxCnt) || retire);

   always_comb begin
      ent_in       = '0;
      ent_in.valid = gnt_o;
      ent_in.err   = gnt_o && !in_range;
      if (gnt_o && !we_i && in_range) begin
         ent_in.rdata = mem_q[idx];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (gnt_o && !retire) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!gnt_o && retire) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MemWords; i++) begin
            mem_q[i] <= '0;
         end
      end else if (gnt_o && we_i && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   sba_slave_pipe #(
      .Latency(Latency)
   ) u_pipe (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .in_i  (ent_in),
      .out_o (ent_out)
   );

   assign rvalid_o = ent_out.valid;
   assign rdata_o  = ent_out.valid ? ent_out.rdata : 32'h0;
   assign err_o    = ent_out.valid && ent_out.err;

endmodule

// File: tb/tb_sba_slave_mem.sv
// Directed bench for sba_slave_mem with a response scoreboard and a shadow memory.
module tb_sba_slave_mem;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          WORDS = 16;
   localparam int          LAT   = 3;
   localparam int          MAXO  = 2;

   logic        clk, rst_n, req, we, gnt, rvalid, err;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [WORDS];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_rv = 0;

   sba_slave_mem #(
      .BaseAddr(BASE), .MemWords(WORDS), .Latency(LAT), .MaxOutstanding(MAXO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
      .be_i(be), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
      .rdata_o(rdata), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Called at the negedge of a grant cycle: push the response and update the model.
   task automatic model_grant();
      logic [31:0] off;
      logic        inr;
      int          idx;
      exp_t        e;
      off = addr - BASE;
      inr = (off >> 2) < WORDS;
      idx = int'(off >> 2);
      e.rdata = 32'h0;
      e.err   = !inr;
      e.due   = cyc + LAT;
      if (inr && !we) e.rdata = mdl[idx];
      if (inr && we)
         for (int b = 0; b < 4; b++)
            if (be[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
      sb.push_back(e);
   endtask

   // Response monitor: every rvalid must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rvalid) begin
            n_rv++;
            if (sb.size() == 0) begin
               check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rdata", rdata, e.rdata);
               check("err", {31'd0, err}, {31'd0, e.err});
               check("latency_cycle", cyc, e.due);
            end
         end else begin
            check("idle_zero", {rdata[30:0], err}, 32'd0);
         end
      end
   end

   task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
      logic g;
      int   n;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      g = 1'b0;
      n = 0;
      while (!g && n < 20) begin
         @(negedge clk);
         g = gnt;
         if (g) model_grant();
         @(posedge clk); #1;
         n++;
      end
      if (!g) check("grant_timeout", 32'd0, 32'd1);
      req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_empty", sb.size(), 32'd0);
   endtask

   logic [5:0] pat;

   initial begin
      for (int i = 0; i < WORDS; i++) mdl[i] = 32'h0;
      req = 0; we = 0; addr = 0; be = 0; wdata = 0;
      rst_n = 1'b0;
      #1;
      check("rst_gnt", {31'd0, gnt}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // basic write/read
      do_req(1'b1, BASE + 32'h10, 4'hF, 32'hA5A5_1234);
      do_req(1'b0, BASE + 32'h10, 4'hF, 32'h0);
      drain();
      // partial byte write
      do_req(1'b1, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
      do_req(1'b1, BASE + 32'h20, 4'b0101, 32'h0000_0000);
      do_req(1'b0, BASE + 32'h20, 4'hF, 32'h0);
      drain();
      check("partial_model", mdl[8], 32'hFF00_FF00);
      // out of range: one past the end, and below base
      do_req(1'b0, BASE + 4*WORDS, 4'hF, 32'h0);
      do_req(1'b1, BASE + 4*WORDS, 4'hF, 32'hDEAD_BEEF);
      drain();
      do_req(1'b1, BASE - 4, 4'hF, 32'hDEAD_BEEF);
      do_req(1'b0, BASE, 4'hF, 32'h0);
      drain();
      // be=0 still responds and leaves data intact
      do_req(1'b1, BASE + 32'h10, 4'h0, 32'h1111_1111);
      do_req(1'b0, BASE + 32'h10, 4'hF, 32'h0);
      drain();
      // write then read same word on the following cycle
      do_req(1'b1, BASE + 32'h3C, 4'hF, 32'h0BAD_F00D);
      do_req(1'b0, BASE + 32'h3C, 4'hF, 32'h0);
      drain();

      // grant throttling with req held high
      pat = 6'b011011;
      req = 1'b1; we = 1'b0; addr = BASE + 32'h10; be = 4'hF;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("gnt_pat%0d", i), {31'd0, gnt}, {31'd0, pat[i]});
         if (gnt) model_grant();
         @(posedge clk); #1;
      end
      req = 1'b0;
      drain();

      // reset with two reads in flight
      do_req(1'b0, BASE + 32'h10, 4'hF, 32'h0);
      do_req(1'b0, BASE + 32'h20, 4'hF, 32'h0);
      rst_n = 1'b0;
      sb.delete();
      for (int i = 0; i < WORDS; i++) mdl[i] = 32'h0;
      #1;
      check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
      check("midrst_cnt", {29'd0, dut.cnt_q}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      n_rv = 0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      check("post_rst_no_rvalid", n_rv, 32'd0);
      for (int i = 0; i < WORDS; i++) do_req(1'b0, BASE + 4*i, 4'hF, 32'h0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim did not finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
